// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default bit period and frame
// geometry. Used by the transmitter and, later, by the matching receiver.
package uart_pkg;

  // 50 MHz system clock / 19200 baud
  localparam int unsigned BAUD_CLKS_DEFAULT = 2604;
  localparam int unsigned BAUD_CNT_W        = 12;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } state_t;

  // Frame image as it sits in the shift register: start bit in the LSB,
  // data LSB first, stop bit on top.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle of the UART transmitter.
// master: the client that queues bytes; slave: the transmitter itself.
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       clr_done;
  logic       TX;
  logic       tx_rdy;
  logic       tx_done;

  modport master (
    output trmt,
    output tx_data,
    output clr_done,
    input  TX,
    input  tx_rdy,
    input  tx_done
  );

  modport slave (
    input  trmt,
    input  tx_data,
    input  clr_done,
    output TX,
    output tx_rdy,
    output tx_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_CLKS-1 while enabled and pulses
// tick_o in the last cycle of each bit period, wrapping to 0 there.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CLKS = BAUD_CLKS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(BAUD_CLKS - 1);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then wrap at the last cycle, else count up.
  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + BAUD_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first. TX is bit 0 of the frame shift
// register, so the line is registered and returns high asynchronously
// on reset (the shift register resets to all ones).
// Optional feature: define UART_TX_BUF_EN to add a one-deep hold
// register so a second byte can be queued and sent back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CLKS = BAUD_CLKS_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);

  state_t                 state_q;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   done_q;

  logic                   tick;
  logic                   frame_end;
  logic                   tx_rdy;
  logic                   accept;
  logic                   load;
  logic [7:0]             load_byte;

`ifdef UART_TX_BUF_EN
  logic [7:0]             hold_q, hold_d;
  logic                   hold_vld_q, hold_vld_d;
`endif

  uart_baud_cnt #(
    .BAUD_CLKS (BAUD_CLKS)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load),
    .en_i   (state_q == TRANSMITTING),
    .tick_o (tick)
  );

  // Accept/load decisions and next shift-register / bit-counter values.
  always_comb begin
    frame_end = (state_q == TRANSMITTING) && tick &&
                (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
`ifdef UART_TX_BUF_EN
    tx_rdy = !hold_vld_q;
`else
    tx_rdy = (state_q == IDLE);
`endif
    accept    = bus.trmt && tx_rdy;
    load      = 1'b0;
    load_byte = bus.tx_data;
`ifdef UART_TX_BUF_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (frame_end && hold_vld_q) begin
      // queued byte starts right behind the stop bit
      load       = 1'b1;
      load_byte  = hold_q;
      hold_vld_d = 1'b0;
    end else if (accept) begin
      if ((state_q == IDLE) || frame_end) begin
        load = 1'b1;
      end else begin
        hold_d     = bus.tx_data;
        hold_vld_d = 1'b1;
      end
    end
`else
    load = accept;
`endif

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shift_d   = frame_word(load_byte);
      bit_cnt_d = '0;
    end else if ((state_q == TRANSMITTING) && tick) begin
      shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  // Control FSM and sticky done flag (set has priority over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:         if (load) state_q <= TRANSMITTING;
        TRANSMITTING: if (frame_end && !load) state_q <= IDLE;
        default:      state_q <= IDLE;
      endcase
      if (frame_end) begin
        done_q <= 1'b1;
      end else if (accept || bus.clr_done) begin
        done_q <= 1'b0;
      end
    end
  end

  // Frame shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '1;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef UART_TX_BUF_EN
  // One-deep hold register for a byte queued during a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  assign bus.TX      = shift_q[0];
  assign bus.tx_rdy  = tx_rdy;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random bytes, checked every
// cycle against a frame-timing model and by a decoding line receiver.
module tb_uart_tx;

  localparam int B  = 16;
  localparam int FB = 10;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_if u_if ();

  uart_tx #(.BAUD_CLKS(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame described by its first TX cycle and its byte.
  int         cyc     = 0;
  int         m_start = 0;
  logic [7:0] m_byte  = 8'h00;
  bit         m_act   = 1'b0;
  bit         m_pend  = 1'b0;
  logic [7:0] m_pbyte = 8'h00;
  bit         m_done  = 1'b0;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  bit         rx_en   = 1'b1;

  function automatic bit m_win(input int cc);
    return m_act && (cc >= m_start) && (cc < m_start + FB*B);
  endfunction

  function automatic logic m_tx(input int cc);
    logic [9:0] fr;
    if (!m_win(cc)) return 1'b1;
    fr = {1'b1, m_byte, 1'b0};
    return fr[(cc - m_start) / B];
  endfunction

  function automatic logic m_rdy();
`ifdef UART_TX_BUF_EN
    return !m_pend;
`else
    return !m_win(cyc);
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs, advance model.
  task automatic step(input logic t, input logic [7:0] d, input logic cl);
    logic e_tx, e_rdy;
    bit   fe, acc;
    @(posedge clk);
    #1;
    u_if.trmt     = t;
    u_if.tx_data  = d;
    u_if.clr_done = cl;
    @(negedge clk);
    e_tx  = m_tx(cyc);
    e_rdy = m_rdy();
    chk("TX", u_if.TX, e_tx);
    chk("tx_rdy", u_if.tx_rdy, e_rdy);
    chk("tx_done", u_if.tx_done, m_done);
    fe  = m_act && (cyc == m_start + FB*B - 1);
    acc = t && e_rdy;
    if (acc) sent_q.push_back(d);
    if (acc || cl) m_done = 1'b0;
    if (fe) m_done = 1'b1;
`ifdef UART_TX_BUF_EN
    if (fe && m_pend) begin
      m_start = cyc + 1; m_byte = m_pbyte; m_pend = 1'b0;
    end else if (acc) begin
      if (m_win(cyc) && !fe) begin
        m_pend = 1'b1; m_pbyte = d;
      end else begin
        m_start = cyc + 1; m_byte = d; m_act = 1'b1;
      end
    end
`else
    if (acc) begin
      m_start = cyc + 1; m_byte = d; m_act = 1'b1;
    end
`endif
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 40*FB*B && cyc < target; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 40*FB*B && !m_rdy(); i++)
      step(1'b0, 8'($urandom), ($urandom_range(0, 31) == 0));
    if (!m_rdy()) chk("rdy_wait", u_if.tx_rdy, 1);
  endtask

  // Line receiver: mid-bit sampling, independent of the model.
  initial begin : rx_proc
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && u_if.TX === 1'b0) begin
        repeat (B/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          rb[i] = u_if.TX;
        end
        repeat (B) @(negedge clk);
        rx_q.push_back(rb);
      end
    end
  end

  initial begin : watchdog
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fs, n;
    logic [7:0] b;
    rst_n         = 1'b0;
    u_if.trmt     = 1'b0;
    u_if.tx_data  = 8'h00;
    u_if.clr_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_TX", u_if.TX, 1);
    chk("rst_tx_rdy", u_if.tx_rdy, 1);
    chk("rst_tx_done", u_if.tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // A5 frame with ignored/queued strobes mid-frame and at frame end
    step(1'b1, 8'hA5, 1'b0);
    fs = m_start;
    run_to(fs + 5*B);
    step(1'b1, 8'h3C, 1'b0);
    run_to(fs + FB*B - 1);
    step(1'b1, 8'h3C, 1'b0);
    idle(25*B);

    // 11 then 22 mid-frame, then 33 while the hold slot is full
    wait_rdy();
    step(1'b1, 8'h11, 1'b0);
    fs = m_start;
    run_to(fs + 3*B);
    step(1'b1, 8'h22, 1'b0);
    idle(2*B);
    step(1'b1, 8'h33, 1'b0);
    idle(25*B);

    // clr_done in the frame-end cycle loses to the set
    wait_rdy();
    step(1'b1, 8'h5A, 1'b0);
    fs = m_start;
    run_to(fs + FB*B - 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("done_set_prio", u_if.tx_done, 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("done_clr", u_if.tx_done, 0);

    // corner bytes then random bytes, random spacing
    for (int i = 0; i < 35; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h55 : 8'($urandom);
      wait_rdy();
      step(1'b1, b, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(25*B);

    chk("rx_count", rx_q.size(), sent_q.size());
    n = (rx_q.size() < sent_q.size()) ? rx_q.size() : sent_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("rx_byte%0d", i), rx_q[i], sent_q[i]);

    // reset in the middle of bit 4
    rx_en = 1'b0;
    wait_rdy();
    step(1'b1, 8'hC3, 1'b0);
    fs = m_start;
    run_to(fs + 4*B + B/2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_TX", u_if.TX, 1);
    chk("midrst_tx_done", u_if.tx_done, 0);
    chk("midrst_tx_rdy", u_if.tx_rdy, 1);
    m_act  = 1'b0;
    m_pend = 1'b0;
    m_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12*B);

    // line still usable after reset
    step(1'b1, 8'h96, 1'b0);
    idle(12*B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serializing one byte per frame (8N1, LSB first, one start bit, one stop bit) onto the TX line. It is the transmit counterpart of the team's UART receiver. The two share the same baud constant, so a TX→RX loopback is bit-exact. It is used by the command/telemetry path to send bytes from the flight controller to the host.

## Interface
- BAUD_CLKS, 2604: clk cycles per bit (50 MHz / 19200 baud); 12-bit baud counter.
- clk  input  1  system clock, all flops rising edge
- rst_n  input  1  asynchronous active-low reset
- trmt  input  1  one-cycle strobe requesting transmission of tx_data; honored only when tx_rdy=1
- tx_data  input  8  byte to send, sampled in the cycle trmt is accepted
- clr_done  input  1  synchronous clear of tx_done
- TX  output  1  serial line, registered; idles high
- tx_rdy  output  1  high when a trmt this cycle will be accepted
- tx_done  output  1  sticky frame-complete flag

## Operation
- Reset values: TX=1, tx_done=0, tx_rdy=1, state IDLE, shift register all ones, hold register empty.
- The FSM has two states, IDLE and TRANSMITTING.
- IDLE transitions to TRANSMITTING on an accepted trmt:
  - The 10-bit shift register loads {1'b1, tx_data, 1'b0}.
  - The baud counter is cleared to 0.
  - The bit counter is cleared to 0.
- In TRANSMITTING:
  - TX = shift_reg[0].
  - The baud counter increments every cycle.
  - When it reaches BAUD_CLKS-1 it wraps to 0, the shift register shifts right with fill 1, and the bit counter increments.
- Frame end is the shift that takes the bit counter to 10.
  - tx_done is set.
  - The next state is IDLE, unless a pending byte exists (see Configuration).
- tx_done is an SR flop. Set has priority over clear. Clear comes from an accepted trmt or from clr_done.
- Without the buffer, tx_rdy = (state==IDLE).
  - A trmt while TRANSMITTING is ignored; tx_data is not captured.
  - This includes the frame-end cycle.
- Reset asserted mid-frame: TX returns to 1 immediately (asynchronously), the frame is abandoned, and no partial byte is resent after reset.

## Timing
- Accepted trmt in cycle N: TX goes low (start bit) from cycle N+1.
- Each bit, including start and stop, is held exactly BAUD_CLKS cycles.
- A frame occupies TX for 10·BAUD_CLKS cycles (26040 at the default).
- tx_done rises in the cycle after the last stop-bit cycle. TX stays 1 thereafter.
- Minimum gap between frames:
  - Without the buffer: 1 cycle, because IDLE must be re-entered before the next trmt is accepted.
  - With the buffer: 0 cycles.
- The counter arithmetic is unsigned, and the baud counter never exceeds BAUD_CLKS-1.

## Configuration
- The macro is UART_TX_BUF_EN.
- When the macro is defined, the block compiles in a one-deep hold register (8-bit data plus a valid bit).
  - tx_rdy = !hold_valid.
  - A trmt in IDLE loads the shift register directly, and the hold register stays empty.
  - A trmt in TRANSMITTING fills the hold register.
  - At frame end with hold_valid=1, the shift register loads the held byte in the same edge. The next start bit follows the stop bit with no idle cycle, the FSM stays in TRANSMITTING, hold_valid clears, and tx_done is still set.
  - A trmt in the frame-end cycle with hold empty loads the shift register directly, also with no gap.
- When the macro is undefined, there is no hold register and the behavior is exactly as stated in Operation.

## Structure
- Package uart_pkg holds:
  - the state_t enum (IDLE, TRANSMITTING);
  - the BAUD_CLKS default constant, shared with the receiver;
  - the FRAME_BITS=10 constant.
- One natural sub-module is uart_baud_cnt: a counter with clear, enable, and wrap at BAUD_CLKS-1 that emits a tick. It is reusable by the receiver later.
- The shift register, bit counter, tx_done SR flop, and hold register live in uart_tx.

## Test plan
- Reset then trmt with tx_data=8'hA5 → TX low for 2604 cycles, then the bits 1,0,1,0,0,1,0,1, then stop high. tx_done rises 26040 cycles after the start bit. tx_rdy is low throughout the frame.
- Loopback into the team's UART receiver for 8'h00, 8'hFF, 8'h55 and 32 random bytes → received byte equals the sent byte every time.
- Without the buffer, pulse trmt (8'h3C) mid-frame and in the frame-end cycle → both ignored; the frame in flight is unchanged and no second frame occurs.
- With UART_TX_BUF_EN, trmt 8'h11 then trmt 8'h22 mid-frame → two back-to-back frames with no idle cycle between the stop bit and the next start bit. tx_rdy is low while hold is full. A third trmt while full is ignored.
- Assert rst_n low at bit 4 of a frame → TX=1, tx_done=0, tx_rdy=1 immediately. After release, the line stays idle until a new trmt.
- tx_done is set, then clr_done and frame end land in the same cycle → tx_done remains 1 (set priority). A later clr_done alone → 0.
